// File: rtl/ram_dump_reader_if.sv
// Bundle of the request, RAM read port and output stream signals of ram_dump_reader.
// Signal prefixes are from the reader's point of view: i_ enters the reader, o_ leaves it.
interface ram_dump_reader_if #(
  parameter int XLEN     = 32,
  parameter int RAM_SIZE = 'h600,
  parameter int ADDR_W   = $clog2(RAM_SIZE)
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_count;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_mem_re;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   i_mem_rdata;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [XLEN-1:0]   o_out_data;
  logic              o_out_last;
  logic [XLEN-1:0]   o_checksum;

  modport slave (
    input  i_start, i_base_addr, i_count, i_mem_rdata, i_out_ready,
    output o_busy, o_done, o_err, o_mem_re, o_mem_addr,
           o_out_valid, o_out_data, o_out_last, o_checksum
  );

  modport master (
    output i_start, i_base_addr, i_count, i_mem_rdata, i_out_ready,
    input  o_busy, o_done, o_err, o_mem_re, o_mem_addr,
           o_out_valid, o_out_data, o_out_last, o_checksum
  );
endinterface

// File: rtl/ram_dump_reader.sv
// Streams a contiguous range of RAM words out of a synchronous read port onto a
// valid/ready stream, marking the final word and keeping a running checksum.
module ram_dump_reader #(
  parameter int XLEN     = 32,
  parameter int RAM_SIZE = 'h600,
  parameter int ADDR_W   = $clog2(RAM_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  ram_dump_reader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [XLEN-1:0]   r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_fcount;
  logic              r_err;
  logic [XLEN-1:0]   r_checksum;

  logic [ADDR_W+1:0] w_end;
  logic              w_range_ok;
  logic              w_accept;
  logic              w_valid;
  logic              w_pop;
  logic              w_head_last;
  logic [2:0]        w_occupancy;
  logic              w_issue;

  // End index is two bits wider than an address so base+count can never wrap.
  assign w_end       = {2'b00, bus.i_base_addr} + {1'b0, bus.i_count};
  assign w_range_ok  = (w_end <= (ADDR_W+2)'(RAM_SIZE));
  assign w_accept    = (r_state == S_IDLE) && bus.i_start;
  assign w_valid     = (r_fcount != 2'd0);
  assign w_pop       = w_valid && bus.i_out_ready;
  assign w_head_last = r_fifo_last[r_rptr];
  assign w_occupancy = {1'b0, r_fcount} + {2'b00, r_inflight};

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = (r_state == S_FIN);
  assign bus.o_err       = r_err;
  assign bus.o_mem_re    = w_issue;
  assign bus.o_mem_addr  = r_addr;
  assign bus.o_out_valid = w_valid;
  assign bus.o_out_data  = r_fifo_data[r_rptr];
  assign bus.o_out_last  = w_valid && w_head_last;
  assign bus.o_checksum  = r_checksum;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and read issue; a word leaving the buffer this cycle frees its slot,
  // which keeps the stream bubble-free with two buffer entries.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_next = ((bus.i_count != '0) && w_range_ok) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        if (w_occupancy <= ({2'b00, w_pop} + 3'd1)) begin
          w_issue = 1'b1;
          if (r_remaining == (ADDR_W+1)'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request bookkeeping: latch the range on accept, then walk it one read at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= bus.i_base_addr;
        r_remaining <= bus.i_count;
        r_err       <= !w_range_ok;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == (ADDR_W+1)'(1));
    end
  end

  // Two-entry buffer: returning RAM data is written the cycle after its read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= 2'b00;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_fcount       <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wptr] <= bus.i_mem_rdata;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({r_inflight, w_pop})
        2'b10:   r_fcount <= r_fcount + 2'd1;
        2'b01:   r_fcount <= r_fcount - 2'd1;
        default: r_fcount <= r_fcount;
      endcase
    end
  end

  // Running checksum of handshaken words, restarted by each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_checksum <= '0;
    else if (w_accept) r_checksum <= '0;
    else if (w_pop)    r_checksum <= r_checksum + r_fifo_data[r_rptr];
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: a RAM model behind the read port, directed and random
// requests, and expectations derived from the RAM contents and the requested range.
module tb_ram_dump_reader;
  localparam int XLEN     = 32;
  localparam int RAM_SIZE = 'h600;
  localparam int ADDR_W   = $clog2(RAM_SIZE);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [XLEN-1:0] ram [RAM_SIZE];

  ram_dump_reader_if #(.XLEN(XLEN), .RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W)) bus ();

  ram_dump_reader #(.XLEN(XLEN), .RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock.
  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (bus.o_mem_re) bus.i_mem_rdata <= ram[bus.o_mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic readyFor(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // One request from start to the cycle after done, checked against the RAM contents.
  task automatic applyStimulus(input int base, input int count, input int mode,
                               input int injectBase);
    bit              expErr;
    bit              nominal;
    int              cyc, got, issued, doneCyc, lastHsCyc;
    bit              doneSeen, prevStall, prevLast, hs;
    logic [XLEN-1:0] prevData, expSum, doneSum;
    logic            doneErr;
    expErr   = (base + count) > RAM_SIZE;
    nominal  = !expErr && (count != 0);
    cyc = 0; got = 0; issued = 0; doneCyc = -1; lastHsCyc = -10;
    doneSeen = 0; prevStall = 0; prevLast = 0; prevData = '0; expSum = '0;
    doneSum = '0; doneErr = 1'b0;
    @(posedge clk); #1;
    bus.i_start     = 1'b1;
    bus.i_base_addr = ADDR_W'(base);
    bus.i_count     = (ADDR_W+1)'(count);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    checkOutput("busy_after_start", 32'(bus.o_busy), 32'd1);
    while (!doneSeen && cyc < 300) begin
      bus.i_out_ready = readyFor(mode, cyc);
      if (injectBase >= 0 && cyc == 2) begin
        bus.i_start     = 1'b1;
        bus.i_base_addr = ADDR_W'(injectBase);
        bus.i_count     = (ADDR_W+1)'(3);
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      hs = bus.o_out_valid && bus.i_out_ready;
      if (prevStall) begin
        checkOutput("stall_valid", 32'(bus.o_out_valid), 32'd1);
        checkOutput("stall_data", bus.o_out_data, prevData);
        checkOutput("stall_last", 32'(bus.o_out_last), 32'(prevLast));
      end
      prevStall = bus.o_out_valid && !bus.i_out_ready;
      prevData  = bus.o_out_data;
      prevLast  = bus.o_out_last;
      if (bus.o_mem_re) begin
        checkOutput("mem_addr", 32'(bus.o_mem_addr), 32'(base + issued));
        issued++;
      end
      if (hs) begin
        checkOutput("out_data", bus.o_out_data, ram[(base + got) % RAM_SIZE]);
        checkOutput("out_last", 32'(bus.o_out_last), 32'(got == count - 1));
        expSum = expSum + ram[(base + got) % RAM_SIZE];
        got++;
        lastHsCyc = cyc;
      end
      if (nominal) checkOutput("occupancy_le2", 32'((issued - got) <= 2), 32'd1);
      if (bus.o_done) begin
        doneSeen = 1; doneCyc = cyc; doneSum = bus.o_checksum; doneErr = bus.o_err;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_start = 1'b0;
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
    checkOutput("err_at_done", 32'(doneErr), 32'(expErr));
    checkOutput("words_streamed", 32'(got), nominal ? 32'(count) : 32'd0);
    checkOutput("reads_issued", 32'(issued), nominal ? 32'(count) : 32'd0);
    checkOutput("checksum_at_done", doneSum, expSum);
    checkOutput("done_timing", 32'(doneCyc), nominal ? 32'(lastHsCyc + 1) : 32'd0);
    @(negedge clk);
    checkOutput("idle_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("idle_done", 32'(bus.o_done), 32'd0);
    checkOutput("checksum_hold", bus.o_checksum, expSum);
    checkOutput("err_hold", 32'(bus.o_err), 32'(expErr));
    bus.i_out_ready = 1'b0;
  endtask

  initial begin
    int got;
    int base;
    int count;
    for (int i = 0; i < RAM_SIZE; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram['h10 + i] = 32'(i + 1);
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_count     = '0;
    bus.i_out_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.o_done), 32'd0);
    checkOutput("rst_err", 32'(bus.o_err), 32'd0);
    checkOutput("rst_mem_re", 32'(bus.o_mem_re), 32'd0);
    checkOutput("rst_valid", 32'(bus.o_out_valid), 32'd0);
    checkOutput("rst_last", 32'(bus.o_out_last), 32'd0);
    checkOutput("rst_checksum", bus.o_checksum, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic four-word dump");
    applyStimulus('h10, 4, 0, -1);
    checkOutput("t1_checksum_10", bus.o_checksum, 32'd10);

    $display("[TB] same dump with stalling consumer");
    applyStimulus('h10, 4, 1, -1);

    $display("[TB] zero-length request");
    applyStimulus(0, 0, 0, -1);

    $display("[TB] range overflow, then exact-fit range");
    applyStimulus('h5FE, 4, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_held_idle", 32'(bus.o_err), 32'd1);
    applyStimulus('h5FC, 4, 0, -1);

    $display("[TB] start while busy is ignored");
    applyStimulus(100, 8, 1, 300);

    $display("[TB] reset in the middle of a dump");
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_base_addr = ADDR_W'(200); bus.i_count = (ADDR_W+1)'(8);
    bus.i_out_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got < 2; c++) begin
      @(negedge clk);
      checkOutput("t6_no_done_before_rst", 32'(bus.o_done), 32'd0);
      if (bus.o_out_valid && bus.i_out_ready) got++;
      @(posedge clk); #1;
    end
    checkOutput("t6_two_words_seen", 32'(got), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("t6_valid_drop", 32'(bus.o_out_valid), 32'd0);
    checkOutput("t6_busy_drop", 32'(bus.o_busy), 32'd0);
    checkOutput("t6_mem_re_drop", 32'(bus.o_mem_re), 32'd0);
    checkOutput("t6_checksum_clr", bus.o_checksum, 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("t6_no_done_in_rst", 32'(bus.o_done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(200, 8, 0, -1);

    $display("[TB] random requests");
    for (int i = 0; i < 10; i++) begin
      count = $urandom_range(0, 12);
      if (i % 2 == 1) base = RAM_SIZE - $urandom_range(1, 10);
      else            base = $urandom_range(0, RAM_SIZE - 1);
      applyStimulus(base, count, $urandom_range(0, 2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
